uart_rx_decoder: RTL and testbench
==================================

Name: uart_rx_decoder

Overview:
Synthesizable UART receiver (8N1 by default) that recovers bytes from a serial line, e.g. the SoC `tx` pin, inside the simulation top.
- Replaces per-clock dumping of the raw `tx` waveform with decoded bytes plus framing status.
- Single clock domain.
- Serial input is asynchronous and is synchronized internally.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit period. Must be ≥ 4 and even.
- DATA_BITS, 8: data bits per frame, LSB first, range 5..8.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous reset, active-high.
- rx_i, input, 1: serial line, idle high, asynchronous to clk_i.
- data_o, output, 8: last received byte. Bits ≥ DATA_BITS read 0.
- valid_o, output, 1: one-cycle pulse, data_o newly updated.
- frame_err_o, output, 1: one-cycle pulse, stop bit sampled low.
- busy_o, output, 1: high whenever the FSM is not in IDLE.
- byte_cnt_o, output, 16: count of good frames, wraps 0xFFFF→0.

Behaviour:
- Reset values, applied while rst_i=1 on a clk_i edge:
  - data_o=0, valid_o=0, frame_err_o=0, busy_o=0, byte_cnt_o=0.
  - Synchronizer flops set to 1; FSM=IDLE; all counters 0.
  - Reset mid-frame aborts the frame silently: no valid_o, no frame_err_o.
- Synchronizer: two flops rx_i→rx_s, plus a third flop rx_d for edge detection.
- Counters: baud counter width $clog2(CLKS_PER_BIT); bit counter width $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_d=1 and rx_s=0 (falling edge): go to START, baud counter=0. Call this cycle t0.
  - A line that is low out of reset, with no high seen since, does not start a frame.
- START:
  - Sample rx_s when baud counter = CLKS_PER_BIT/2-1, i.e. at t0+CLKS_PER_BIT/2.
  - Sample 0: go to DATA, baud counter=0, bit counter=0.
  - Sample 1: glitch; return to IDLE with no output.
- DATA:
  - Sample when baud counter = CLKS_PER_BIT-1.
  - Data bit i is sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shifted in LSB first.
  - After bit DATA_BITS-1, go to STOP.
- STOP:
  - Sample one bit period after the last data bit.
  - Sample 1, on the next cycle:
    - data_o updates, valid_o=1 for exactly one cycle.
    - byte_cnt_o increments.
    - FSM goes to IDLE.
  - Sample 0, on the next cycle:
    - frame_err_o=1 for exactly one cycle.
    - data_o is not updated and byte_cnt_o is not incremented.
    - FSM goes to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A line held low (break) therefore generates exactly one frame_err_o.
- Latency (8N1): valid_o is high at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT+1, i.e. 2+that cycles after the rx_i edge, because of the 2-flop synchronizer.
- Back-to-back frames:
  - IDLE is reached half a bit into the stop bit.
  - The next start edge is accepted from the following cycle.
  - A new start edge in the same cycle that valid_o pulses is accepted.
- valid_o and frame_err_o are never high in the same cycle.
- data_o holds its value until the next good frame. There is no overrun flag; the consumer must take data within one frame time.
- busy_o = (FSM != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame carries one even-parity bit after the data bits, sampled one bit period after the last data bit; STOP follows one bit period later.
  - Adds output par_err_o, 1 bit. It pulses together with valid_o when the XOR of the data bits and the parity bit is 1.
  - data_o is still updated and byte_cnt_o still increments on a parity error.
  - par_err_o resets to 0.
- Undefined: no parity bit, no par_err_o port, timing as in Behaviour.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8 unless stated):
- Drive frame 0x55 (start, 10101010, stop), 4 cycles per bit → one valid_o pulse, data_o=0x55, byte_cnt_o=1, frame_err_o never high, busy_o low afterwards.
- Drive a 1-cycle low glitch on an idle line → no valid_o, no frame_err_o; FSM back in IDLE within CLKS_PER_BIT/2+3 cycles.
- Drive frame 0xA3 with stop bit low, then line low for 40 cycles, then high, then frame 0x3C → exactly one frame_err_o; data_o stays at previous value then becomes 0x3C; byte_cnt_o increments once.
- Drive frames 0x00, 0xFF, 0x7E back-to-back with no idle bits → three valid_o pulses, data_o sequence 0x00, 0xFF, 0x7E; pulse spacing exactly 10*CLKS_PER_BIT cycles.
- Assert rst_i for 1 cycle during data bit 3 of a frame, then send 0x41 → no output from the aborted frame; data_o=0x41, byte_cnt_o=1.
- With UART_RX_PARITY_EN defined: send 0x07 with parity 1 → valid_o, par_err_o=0. Send 0x07 with parity 0 → valid_o with par_err_o=1, data_o=0x07.

Source files
------------

// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: UART receiver, 8N1 by default. It recovers bytes from an
// asynchronous serial line and reports each frame as valid data or a framing
// error, and it keeps a running count of good frames.
// Optional feature macro: UART_RX_PARITY_EN. When defined, one even-parity bit
// is expected between the data bits and the stop bit, and par_err_o is added.
module uart_rx_decoder #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic        par_err_o,
`endif
    output logic        busy_o,
    output logic [15:0] byte_cnt_o
);

    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int NW   = $clog2(DATA_BITS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Synchronizer, edge-detect delay and "line has really been high" tracking.
    logic rx_meta_q, rx_s_q, rx_d_q;
    logic vld_meta_q, vld_s_q, seen_high_q;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [NW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic [15:0]            cnt_q, cnt_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   par_err_q, par_err_d;
`endif

    logic start_edge;
    logic baud_half;
    logic baud_last;

    // Bring rx_i into the clock domain; the valid flags stop the reset value of
    // the synchronizer from masquerading as a high line before real data arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            vld_meta_q  <= 1'b0;
            vld_s_q     <= 1'b0;
            seen_high_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_s_q     <= rx_meta_q;
            rx_d_q     <= rx_s_q;
            vld_meta_q <= 1'b1;
            vld_s_q    <= vld_meta_q;
            if (vld_s_q && rx_s_q) begin
                seen_high_q <= 1'b1;
            end
        end
    end

    assign start_edge = seen_high_q & rx_d_q & ~rx_s_q;
    assign baud_half  = (baud_q == BW'(HALF - 1));
    assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            cnt_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            cnt_q     <= cnt_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    // Frame sequencing: mid-bit sampling driven by the baud counter.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        cnt_d     = cnt_q;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        par_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_q + BW'(1);
                if (baud_half) begin
                    baud_d = '0;
                    if (!rx_s_q) begin
                        state_d = DATA;
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_d = par_q ^ rx_s_q;
`endif
                    // The parity bit (if any) uses the slot after the data bits
                    // and must not disturb the shifted data.
                    if (bit_q < NW'(DATA_BITS)) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    end
                    if (bit_q == NW'(FRAME_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + NW'(1);
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        state_d   = IDLE;
                        valid_d   = 1'b1;
                        data_d    = 8'(shift_q);
                        cnt_d     = cnt_q + 16'd1;
`ifdef UART_RX_PARITY_EN
                        par_err_d = par_q;
`endif
                    end else begin
                        state_d = WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != IDLE);
    assign byte_cnt_o  = cnt_q;
`ifdef UART_RX_PARITY_EN
    assign par_err_o   = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb_uart_rx_decoder: directed, table-driven bench for uart_rx_decoder with
// CLKS_PER_BIT=4 and DATA_BITS=8, plus hand sequences for glitch, line break,
// back-to-back frames, mid-frame reset and (optionally) parity.
module tb_uart_rx_decoder;

    localparam int C = 4;
    localparam int N = 8;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (N + 2 + PB) * C;
    localparam int LAT   = 3 + H + (N + 1 + PB) * C;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        busy_o;
    logic [15:0] byte_cnt_o;
`ifdef UART_RX_PARITY_EN
    logic        par_err_o;
`endif

    uart_rx_decoder #(.CLKS_PER_BIT(C), .DATA_BITS(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
        .par_err_o   (par_err_o),
`endif
        .busy_o      (busy_o),
        .byte_cnt_o  (byte_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Monitor: counts pulse cycles and logs every valid_o event.
    int vcnt = 0, fcnt = 0, pcnt = 0, both = 0, busy_cnt = 0;
    logic [7:0] vdata_q[$];
    int         vcyc_q[$];
    always @(negedge clk) begin
        if (valid_o) begin
            vcnt++;
            vdata_q.push_back(data_o);
            vcyc_q.push_back(cyc);
`ifdef UART_RX_PARITY_EN
            if (par_err_o) pcnt++;
`endif
        end
        if (frame_err_o) fcnt++;
        if (valid_o && frame_err_o) both++;
        if (busy_o) busy_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int frame_start;

    // Drive one frame; rx is left at the stop-bit level for the caller.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        frame_start = cyc;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < N; i++) begin
            rx = b[i];
            tick(C);
        end
        if (PB == 1) begin
            rx = par;
            tick(C);
        end
        rx = stop;
        tick(C);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_data;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[6];

    int v0, f0, b0, p0, n0;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55, 1};
        vecs[1] = '{8'hA3, 1'b0, 0, 1, 8'h55, 1};
        vecs[2] = '{8'h3C, 1'b1, 1, 0, 8'h3C, 2};
        vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00, 3};
        vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 4};
        vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81, 5};

        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset data_o", int'(data_o), 0);
        check("reset valid_o", int'(valid_o), 0);
        check("reset frame_err_o", int'(frame_err_o), 0);
        check("reset busy_o", int'(busy_o), 0);
        check("reset byte_cnt_o", int'(byte_cnt_o), 0);
        tick(2 * C);

        // Table-driven single frames separated by idle time.
        for (int k = 0; k < 6; k++) begin
            v0 = vcnt;
            f0 = fcnt;
            send_frame(vecs[k].b, vecs[k].stop, ^vecs[k].b);
            rx = 1'b1;
            tick(2 * C);
            check($sformatf("row%0d valid pulses", k), vcnt - v0, vecs[k].exp_v);
            check($sformatf("row%0d frame_err pulses", k), fcnt - f0, vecs[k].exp_f);
            check($sformatf("row%0d data_o", k), int'(data_o), int'(vecs[k].exp_data));
            check($sformatf("row%0d byte_cnt_o", k), int'(byte_cnt_o), vecs[k].exp_cnt);
            check($sformatf("row%0d busy_o idle", k), int'(busy_o), 0);
            if (vecs[k].exp_v == 1 && vcnt > v0)
                check($sformatf("row%0d latency", k), vcyc_q[$] - frame_start, LAT);
        end

        // One-cycle glitch on an idle line.
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        check("glitch busy_o during START", int'(busy_o), 1);
        tick(2);
        check("glitch busy_o back idle", int'(busy_o), 0);
        tick(2 * C);
        check("glitch valid pulses", vcnt - v0, 0);
        check("glitch frame_err pulses", fcnt - f0, 0);

        // Bad stop bit followed by a 40-cycle break, then a good frame.
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'hA3, 1'b0, ^8'hA3);
        tick(40);
        check("break busy_o held", int'(busy_o), 1);
        rx = 1'b1;
        tick(2 * C);
        check("break frame_err pulses", fcnt - f0, 1);
        check("break valid pulses", vcnt - v0, 0);
        check("break data_o kept", int'(data_o), 8'h81);
        check("break byte_cnt_o kept", int'(byte_cnt_o), 5);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        tick(2 * C);
        check("after break data_o", int'(data_o), 8'h3C);
        check("after break byte_cnt_o", int'(byte_cnt_o), 6);
        check("after break frame_err pulses", fcnt - f0, 1);

        // Back-to-back frames with no idle bits between them.
        v0 = vcnt;
        n0 = vdata_q.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0);
        tick(2 * C);
        check("b2b valid pulses", vcnt - v0, 3);
        if (vdata_q.size() == n0 + 3) begin
            check("b2b data 0", int'(vdata_q[n0]), 8'h00);
            check("b2b data 1", int'(vdata_q[n0 + 1]), 8'hFF);
            check("b2b data 2", int'(vdata_q[n0 + 2]), 8'h7E);
            check("b2b spacing 0-1", vcyc_q[n0 + 1] - vcyc_q[n0], FRAME);
            check("b2b spacing 1-2", vcyc_q[n0 + 2] - vcyc_q[n0 + 1], FRAME);
        end
        check("b2b byte_cnt_o", int'(byte_cnt_o), 9);

        // Reset during data bit 3 of an all-zero frame; the line is still low
        // when reset releases, so nothing may start until it has been high.
        v0 = vcnt;
        f0 = fcnt;
        rx = 1'b0;
        tick(C);
        tick(3 * C);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        b0 = busy_cnt;
        tick(C - 2);
        tick(4 * C);
        check("reset-mid busy_o while low", busy_cnt - b0, 0);
        rx = 1'b1;
        tick(C);
        tick(2 * C);
        check("reset-mid valid pulses", vcnt - v0, 0);
        check("reset-mid frame_err pulses", fcnt - f0, 0);
        check("reset-mid byte_cnt_o", int'(byte_cnt_o), 0);
        check("reset-mid data_o", int'(data_o), 0);
        send_frame(8'h41, 1'b1, ^8'h41);
        rx = 1'b1;
        tick(2 * C);
        check("post-reset valid pulses", vcnt - v0, 1);
        check("post-reset data_o", int'(data_o), 8'h41);
        check("post-reset byte_cnt_o", int'(byte_cnt_o), 1);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones, so even parity requires a 1.
        v0 = vcnt;
        p0 = pcnt;
        send_frame(8'h07, 1'b1, 1'b1);
        tick(2 * C);
        check("parity ok valid pulses", vcnt - v0, 1);
        check("parity ok par_err pulses", pcnt - p0, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        tick(2 * C);
        check("parity bad valid pulses", vcnt - v0, 2);
        check("parity bad par_err pulses", pcnt - p0, 1);
        check("parity bad data_o", int'(data_o), 8'h07);
        check("parity bad byte_cnt_o", int'(byte_cnt_o), 3);
`endif

        check("valid/frame_err overlap cycles", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
